scan_channel_sequencer: RTL and testbench
=========================================

Name: scan_channel_sequencer

Overview:
- Sequences an 8-way one-hot channel-select decoder across enabled channels for the drone sensor/emitter front end.
- Per channel: drives the binary select code, waits a settle time, holds a dwell window, then handshakes one sample request with the downstream sampler.
- Supports single-frame and continuous scanning, masked (skipped) channels, and immediate abort.

Parameters:
- NUM_CH, 8, number of channels; fixed at 8 to match the one-hot decoder.
- SEL_W, 3, select code width; must equal clog2(NUM_CH).
- SETTLE_W, 8, width of settle_cycles.
- DWELL_W, 16, width of dwell_cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin scan; single-cycle pulse, sampled in IDLE only.
- stop  in  1  abort scan; level, sampled every cycle.
- continuous  in  1  1 = restart the next frame automatically; latched at start and at each frame boundary.
- ch_mask  in  NUM_CH  channel enable, bit i = channel i; latched at start and at each frame boundary.
- settle_cycles  in  SETTLE_W  settle length; latched with ch_mask.
- dwell_cycles  in  DWELL_W  dwell length; latched with ch_mask.
- sample_ack  in  1  sampler accepted the request.
- sel_code  out  SEL_W  current channel index, drives the decoder input.
- sel_en  out  1  1 = decoder output is to be honoured; 0 = force all channels off.
- sample_req  out  1  sample request to the sampler.
- busy  out  1  1 in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last enabled channel of a frame is sampled.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, sel_code=0, sel_en=0, sample_req=0, busy=0, frame_done=0, latched config=0.
- State machine: IDLE, SETTLE, DWELL, SAMPLE, ADVANCE.
- IDLE:
  - start=1 with stop=0 and ch_mask!=0: latch the config, load sel_code = lowest set mask bit, go to SETTLE. busy=1 from the next cycle.
  - start with ch_mask==0: ignored, no state change.
  - start and stop in the same cycle: stop wins, start ignored.
- SETTLE:
  - sel_code stable, sel_en=0.
  - Lasts max(settle_cycles,1) cycles, then DWELL.
- DWELL:
  - sel_en=1.
  - Lasts max(dwell_cycles,1) cycles, then SAMPLE.
- SAMPLE:
  - sel_en=1, sample_req=1.
  - sample_req holds until a cycle where sample_ack=1 is sampled; sample_req drops the next cycle and the state moves to ADVANCE.
  - sample_ack outside SAMPLE is ignored.
- ADVANCE (one cycle, sel_en=0):
  - Search for the next set mask bit strictly above sel_code.
  - If found: load it into sel_code, go to SETTLE.
  - If not found: the frame is complete; frame_done=1 for this cycle. Then:
    - continuous=1: re-latch config. If the new mask is nonzero, wrap sel_code to its lowest set bit and go to SETTLE. If the new mask is zero, go to IDLE.
    - continuous=0: go to IDLE.
- stop=1 in any non-IDLE state:
  - Next cycle: state=IDLE, sel_en=0, sample_req=0, busy=0.
  - No frame_done; sel_code keeps its last value.
- Counters:
  - One shared down-counter, wide enough for max(SETTLE_W,DWELL_W), reloaded on each state entry.
  - Zero-length settings never underflow.
- ch_mask changes mid-frame have no effect until the next frame boundary.
- Single enabled channel in continuous mode: that channel is re-settled every frame; sel_en drops for the ADVANCE cycle.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously).

Test Plan:
- mask=8'b0000_0101, settle=2, dwell=3, continuous=0, ack one cycle after req -> sel_code 0 then 2; per channel: 2 cycles sel_en=0, 3 cycles sel_en=1 before req; frame_done pulses once; busy=0 after.
- mask=8'b1000_0000, continuous=1, ack immediate -> sel_code stays 7; frame_done pulses after every sample; scan repeats until stop; busy=0 one cycle after stop.
- stop asserted during SAMPLE with req high, ack held 0 -> next cycle sample_req=0, sel_en=0, busy=0, no frame_done pulse.
- start with mask=0, and start+stop in the same cycle -> busy stays 0, all outputs unchanged.
- settle=0, dwell=0, mask=8'hFF -> each channel gets 1 SETTLE + 1 DWELL cycle; sel_code 0..7 in order, then frame_done.
- Reset pulsed mid-DWELL on channel 3; mask changed from 8'h0F to 8'hF0 mid-frame (continuous) -> after reset all outputs 0 immediately; mask change first takes effect at the next frame, which starts at channel 4.

Source files
------------

// File: rtl/scan_channel_sequencer.sv
//------------------------------------------------------------------------------
// Module : scan_channel_sequencer
// Steps an 8-way channel-select decoder through the enabled channels: settle,
// dwell, then one sample handshake per channel. Single-frame or continuous.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module scan_channel_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = 3,
  parameter int SETTLE_W = 8,
  parameter int DWELL_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                continuous,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic [DWELL_W-1:0]  dwell_cycles,
  input  logic                sample_ack,
  output logic [SEL_W-1:0]    sel_code,
  output logic                sel_en,
  output logic                sample_req,
  output logic                busy,
  output logic                frame_done
);

  localparam int CNT_W = (SETTLE_W > DWELL_W) ? SETTLE_W : DWELL_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_DWELL   = 3'd2,
    S_SAMPLE  = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_sel_code;
  logic                r_sel_en;
  logic                r_sample_req;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_cont;
  logic [NUM_CH-1:0]   r_mask;
  logic [SETTLE_W-1:0] r_settle;
  logic [DWELL_W-1:0]  r_dwell;

  logic                w_next_found;
  logic [SEL_W-1:0]    w_next_code;

  function automatic logic [SEL_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
    f_lowest = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) f_lowest = SEL_W'(i);
  endfunction

  // Counter holds (length - 1) so a zero length still yields one cycle.
  function automatic logic [CNT_W-1:0] f_len(input logic [CNT_W-1:0] n);
    f_len = (n == '0) ? '0 : n - CNT_W'(1);
  endfunction

  always_comb begin
    w_next_found = 1'b0;
    w_next_code  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_sel_code))) begin
        w_next_found = 1'b1;
        w_next_code  = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel_code   <= '0;
      r_sel_en     <= 1'b0;
      r_sample_req <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cont       <= 1'b0;
      r_mask       <= '0;
      r_settle     <= '0;
      r_dwell      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (r_state != S_IDLE && stop) begin
        r_state      <= S_IDLE;
        r_sel_en     <= 1'b0;
        r_sample_req <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !stop && (ch_mask != '0)) begin
              r_cont     <= continuous;
              r_mask     <= ch_mask;
              r_settle   <= settle_cycles;
              r_dwell    <= dwell_cycles;
              r_sel_code <= f_lowest(ch_mask);
              r_cnt      <= f_len(CNT_W'(settle_cycles));
              r_busy     <= 1'b1;
              r_state    <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_cnt == '0) begin
              r_cnt    <= f_len(CNT_W'(r_dwell));
              r_sel_en <= 1'b1;
              r_state  <= S_DWELL;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_DWELL: begin
            if (r_cnt == '0) begin
              r_sample_req <= 1'b1;
              r_state      <= S_SAMPLE;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_SAMPLE: begin
            if (sample_ack) begin
              r_sample_req <= 1'b0;
              r_sel_en     <= 1'b0;
              r_frame_done <= !w_next_found;
              r_state      <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (w_next_found) begin
              r_sel_code <= w_next_code;
              r_cnt      <= f_len(CNT_W'(r_settle));
              r_state    <= S_SETTLE;
            end else if (r_cont) begin
              // Frame boundary: pick up whatever config is presented now.
              r_cont     <= continuous;
              r_mask     <= ch_mask;
              r_settle   <= settle_cycles;
              r_dwell    <= dwell_cycles;
              if (ch_mask != '0) begin
                r_sel_code <= f_lowest(ch_mask);
                r_cnt      <= f_len(CNT_W'(settle_cycles));
                r_state    <= S_SETTLE;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
          default: begin
            r_sel_en     <= 1'b0;
            r_sample_req <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sel_code   = r_sel_code;
  assign sel_en     = r_sel_en;
  assign sample_req = r_sample_req;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_scan_channel_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_scan_channel_sequencer
// Directed bench for scan_channel_sequencer with hand-computed expectations.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_scan_channel_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        continuous;
  logic [7:0]  ch_mask;
  logic [7:0]  settle_cycles;
  logic [15:0] dwell_cycles;
  logic        sample_ack;
  logic [2:0]  sel_code;
  logic        sel_en;
  logic        sample_req;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  scan_channel_sequencer #(
    .NUM_CH(8), .SEL_W(3), .SETTLE_W(8), .DWELL_W(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .continuous   (continuous),
    .ch_mask      (ch_mask),
    .settle_cycles(settle_cycles),
    .dwell_cycles (dwell_cycles),
    .sample_ack   (sample_ack),
    .sel_code     (sel_code),
    .sel_en       (sel_en),
    .sample_req   (sample_req),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int code);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_en"},   32'(sel_en), 0);
    chk({tag, "_req"},  32'(sample_req), 0);
    chk({tag, "_fd"},   32'(frame_done), 0);
    chk({tag, "_sel"},  32'(sel_code), code);
  endtask

  // Entered at the first SETTLE cycle of a channel; leaves one cycle after ADVANCE.
  task automatic chan(input int code, input int ns, input int nd, input int fd);
    for (int k = 0; k < ns; k++) begin
      chk("settle_sel",  32'(sel_code), code);
      chk("settle_en",   32'(sel_en), 0);
      chk("settle_busy", 32'(busy), 1);
      chk("settle_req",  32'(sample_req), 0);
      chk("settle_fd",   32'(frame_done), 0);
      tick();
    end
    for (int k = 0; k < nd; k++) begin
      chk("dwell_en",  32'(sel_en), 1);
      chk("dwell_req", 32'(sample_req), 0);
      chk("dwell_sel", 32'(sel_code), code);
      tick();
    end
    chk("sample_req", 32'(sample_req), 1);
    chk("sample_en",  32'(sel_en), 1);
    sample_ack = 1'b1;
    tick();
    sample_ack = 1'b0;
    chk("adv_req",   32'(sample_req), 0);
    chk("adv_en",    32'(sel_en), 0);
    chk("adv_fd",    32'(frame_done), fd);
    chk("adv_busy",  32'(busy), 1);
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    ch_mask = '0; settle_cycles = '0; dwell_cycles = '0; sample_ack = 1'b0;
    tick(); tick();
    chk_idle("reset", 0);
    reset = 1'b0;
    tick();
    chk_idle("post_reset", 0);

    // Two channels, single frame
    ch_mask = 8'b0000_0101; settle_cycles = 8'd2; dwell_cycles = 16'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chan(0, 2, 3, 0);
    chan(2, 2, 3, 1);
    chk_idle("t1_end", 2);

    // Single channel, continuous, then stop
    ch_mask = 8'h80; continuous = 1'b1; settle_cycles = 8'd1; dwell_cycles = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chan(7, 1, 1, 1);
    chan(7, 1, 1, 1);
    chan(7, 1, 1, 1);
    chk("t2_resettle", 32'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("t2_stop", 7);

    // Stop while request outstanding
    ch_mask = 8'h01; continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t3_req", 32'(sample_req), 1);
    tick();
    chk("t3_req_hold", 32'(sample_req), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("t3_stop", 0);
    tick();
    chk("t3_no_fd", 32'(frame_done), 0);

    // Ignored starts
    ch_mask = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("t4_zero_mask", 0);
    ch_mask = 8'h05; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_idle("t4_start_stop", 0);
    tick();
    chk_idle("t4_after", 0);

    // Zero-length settle/dwell across all channels
    ch_mask = 8'hFF; settle_cycles = 8'd0; dwell_cycles = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) chan(i, 1, 1, (i == 7) ? 1 : 0);
    chk_idle("t5_end", 7);

    // Mask change mid-frame only applies at the next frame
    ch_mask = 8'h0F; continuous = 1'b1; settle_cycles = 8'd1; dwell_cycles = 16'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chan(0, 1, 2, 0);
    ch_mask = 8'hF0;
    chan(1, 1, 2, 0);
    chan(2, 1, 2, 0);
    chan(3, 1, 2, 1);
    chan(4, 1, 2, 0);
    chk("t6_next_sel", 32'(sel_code), 5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("t6_stop", 5);

    // Asynchronous reset mid-DWELL on channel 3
    ch_mask = 8'h0F; continuous = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chan(0, 1, 2, 0);
    chan(1, 1, 2, 0);
    chan(2, 1, 2, 0);
    tick();
    chk("t7_dwell_en", 32'(sel_en), 1);
    chk("t7_dwell_sel", 32'(sel_code), 3);
    #2 reset = 1'b1;
    #1;
    chk_idle("t7_async_reset", 0);
    #1 reset = 1'b0;
    tick();
    chk_idle("t7_after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
